bus_arb2: RTL and testbench

//   Two-source round-robin arbiter that feeds the 2-input bus mux. It takes

---
 rtl/bus_arb2.sv | 121 ++++++++++++
 tb/tb_bus_arb2.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bus_arb2.sv
// Two-source round-robin arbiter driving a 2:1 bus mux select, with a
// valid/ready output handshake, per-source acks and bursts of up to BURST beats.
module bus_arb2 #(
  parameter int BURST = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_1,
  input  logic             req_2,
  input  logic             out_ready,
  output logic             sel,
  output logic             out_valid,
  output logic             ack_1,
  output logic             ack_2,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a beat moves when out_valid & out_ready are both high on a
  // rising edge; the granted source sees ack_x in that same cycle and must
  // hold req_x high until it does.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;        // 1 = source 2 held the last grant
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic             r_out_valid;
  logic             w_beat;

  assign w_beat = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_1 && req_2)  w_state_nxt = r_last ? GNT1 : GNT2;
        else if (req_1)      w_state_nxt = GNT1;
        else if (req_2)      w_state_nxt = GNT2;
      end
      GNT1: begin
        if (w_beat) begin
          if ((r_cnt < LAST_CNT) && req_1) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            // Re-arbitrate on the same edge so a waiting source sees no bubble.
            w_last_nxt = 1'b0;
            w_cnt_nxt  = '0;
            if (req_2)      w_state_nxt = GNT2;
            else if (req_1) w_state_nxt = GNT1;
            else            w_state_nxt = IDLE;
          end
        end
      end
      GNT2: begin
        if (w_beat) begin
          if ((r_cnt < LAST_CNT) && req_2) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            w_last_nxt = 1'b1;
            w_cnt_nxt  = '0;
            if (req_1)      w_state_nxt = GNT1;
            else if (req_2) w_state_nxt = GNT2;
            else            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The select follows the granted source and keeps its value while idle.
  always_comb begin
    case (w_state_nxt)
      GNT1:    w_sel_nxt = 1'b0;
      GNT2:    w_sel_nxt = 1'b1;
      default: w_sel_nxt = r_sel;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sel       <= w_sel_nxt;
      r_out_valid <= (w_state_nxt != IDLE);
    end
  end

  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign ack_1     = (r_state == GNT1) & out_ready;
  assign ack_2     = (r_state == GNT2) & out_ready;
  assign beat_cnt  = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_arb2.sv
// Bench for bus_arb2: a BURST=4 instance checked from a vector table and
// hand-written sequences, plus a BURST=1 instance for strict alternation.
module tb_bus_arb2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_1 = 1'b0;
  logic       req_2 = 1'b0;
  logic       out_ready = 1'b0;

  logic       sel_a, out_valid_a, ack_1_a, ack_2_a;
  logic [1:0] beat_cnt_a, dbg_state_a;
  logic       sel_b, out_valid_b, ack_1_b, ack_2_b;
  logic [0:0] beat_cnt_b;
  logic [1:0] dbg_state_b;

  always #5 clk = ~clk;

  bus_arb2 #(.BURST(4), .CNT_W(2)) u_dut_a (
    .clk(clk), .reset(reset), .req_1(req_1), .req_2(req_2),
    .out_ready(out_ready), .sel(sel_a), .out_valid(out_valid_a),
    .ack_1(ack_1_a), .ack_2(ack_2_a), .beat_cnt(beat_cnt_a),
    .dbg_state(dbg_state_a)
  );

  bus_arb2 #(.BURST(1), .CNT_W(1)) u_dut_b (
    .clk(clk), .reset(reset), .req_1(req_1), .req_2(req_2),
    .out_ready(out_ready), .sel(sel_b), .out_valid(out_valid_b),
    .ack_1(ack_1_b), .ack_2(ack_2_b), .beat_cnt(beat_cnt_b),
    .dbg_state(dbg_state_b)
  );

  // Expected word packs {sel, out_valid, ack_1, ack_2, beat_cnt[1:0]}.
  typedef struct {
    logic       rst;
    logic       r1;
    logic       r2;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic vec_t mk(input logic rst, input logic r1, input logic r2,
                              input logic rdy, input logic e_sel, input logic e_vld,
                              input logic e_a1, input logic e_a2, input logic [1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.r1 = r1; v.r2 = r2; v.rdy = rdy;
    v.exp = {e_sel, e_vld, e_a1, e_a2, e_cnt};
    return v;
  endfunction

  // Drive one cycle of stimulus after the edge, check outputs mid-cycle.
  task automatic apply(input vec_t v, input int dut, input string name);
    logic [5:0] got;
    logic [5:0] exp;
    @(posedge clk);
    #1;
    reset = v.rst; req_1 = v.r1; req_2 = v.r2; out_ready = v.rdy;
    exp_q.push_back(v.exp);
    @(negedge clk);
    if (dut == 0) got = {sel_a, out_valid_a, ack_1_a, ack_2_a, beat_cnt_a};
    else          got = {sel_b, out_valid_b, ack_1_b, ack_2_b, 1'b0, beat_cnt_b};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: sel/vld/ack1/ack2/cnt got %b expected %b", name, got, exp);
    end
    n_checks++;
    if ((ack_1_a & ack_2_a) | (ack_1_b & ack_2_b)) begin
      n_fail++;
      $display("FAIL %s ack_overlap: a=%b%b b=%b%b expected no overlap",
               name, ack_1_a, ack_2_a, ack_1_b, ack_2_b);
    end
  endtask

  initial begin
    // Single source held high: four beats then a fresh grant to the same source.
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,2'd0));
    vecs.push_back(mk(0,1,0,1, 0,0,0,0,2'd0));
    vecs.push_back(mk(0,1,0,1, 0,1,1,0,2'd0));
    vecs.push_back(mk(0,1,0,1, 0,1,1,0,2'd1));
    vecs.push_back(mk(0,1,0,1, 0,1,1,0,2'd2));
    vecs.push_back(mk(0,1,0,1, 0,1,1,0,2'd3));
    vecs.push_back(mk(0,1,0,1, 0,1,1,0,2'd0));
    // Source 1 drops in its second ack cycle; later source 2 also stops early.
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,2'd0));
    vecs.push_back(mk(0,1,0,1, 0,0,0,0,2'd0));
    vecs.push_back(mk(0,1,0,1, 0,1,1,0,2'd0));
    vecs.push_back(mk(0,0,0,1, 0,1,1,0,2'd1));
    vecs.push_back(mk(0,0,0,1, 0,0,0,0,2'd0));
    vecs.push_back(mk(0,0,1,1, 0,0,0,0,2'd0));
    vecs.push_back(mk(0,0,1,1, 1,1,0,1,2'd0));
    vecs.push_back(mk(0,0,0,1, 1,1,0,1,2'd1));
    vecs.push_back(mk(0,0,0,1, 1,0,0,0,2'd0));
    vecs.push_back(mk(0,1,0,1, 1,0,0,0,2'd0));
    vecs.push_back(mk(0,1,0,1, 0,1,1,0,2'd0));
    // Contention: four beats to source 1, straight to source 2 with a
    // three-cycle stall mid-burst, then straight back to source 1.
    vecs.push_back(mk(1,1,1,1, 0,0,0,0,2'd0));
    vecs.push_back(mk(0,1,1,1, 0,0,0,0,2'd0));
    vecs.push_back(mk(0,1,1,1, 0,1,1,0,2'd0));
    vecs.push_back(mk(0,1,1,1, 0,1,1,0,2'd1));
    vecs.push_back(mk(0,1,1,1, 0,1,1,0,2'd2));
    vecs.push_back(mk(0,1,1,1, 0,1,1,0,2'd3));
    vecs.push_back(mk(0,1,1,1, 1,1,0,1,2'd0));
    vecs.push_back(mk(0,1,1,0, 1,1,0,0,2'd1));
    vecs.push_back(mk(0,1,1,0, 1,1,0,0,2'd1));
    vecs.push_back(mk(0,1,1,0, 1,1,0,0,2'd1));
    vecs.push_back(mk(0,1,1,1, 1,1,0,1,2'd1));
    vecs.push_back(mk(0,1,1,1, 1,1,0,1,2'd2));
    vecs.push_back(mk(0,1,1,1, 1,1,0,1,2'd3));
    vecs.push_back(mk(0,1,1,1, 0,1,1,0,2'd0));

    foreach (vecs[i]) apply(vecs[i], 0, $sformatf("tbl[%0d]", i));

    // BURST=1 instance: strict alternation under contention.
    apply(mk(1,1,1,1, 0,0,0,0,2'd0), 1, "b1_reset");
    apply(mk(0,1,1,1, 0,0,0,0,2'd0), 1, "b1_idle");
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) apply(mk(0,1,1,1, 0,1,1,0,2'd0), 1, $sformatf("b1_alt[%0d]", k));
      else            apply(mk(0,1,1,1, 1,1,0,1,2'd0), 1, $sformatf("b1_alt[%0d]", k));
    end

    // Reset asserted mid-burst in GNT2 with beat_cnt=2.
    apply(mk(1,0,0,0, 0,0,0,0,2'd0), 0, "mr_reset");
    apply(mk(0,0,1,1, 0,0,0,0,2'd0), 0, "mr_idle");
    apply(mk(0,0,1,1, 1,1,0,1,2'd0), 0, "mr_beat0");
    apply(mk(0,0,1,1, 1,1,0,1,2'd1), 0, "mr_beat1");
    apply(mk(0,0,1,0, 1,1,0,0,2'd2), 0, "mr_hold2");
    apply(mk(1,1,1,1, 0,0,0,0,2'd0), 0, "mr_async");
    apply(mk(0,1,1,1, 0,0,0,0,2'd0), 0, "mr_release");
    apply(mk(0,1,1,1, 0,1,1,0,2'd0), 0, "mr_first_gnt");

    // Random back-pressure on a held source-1 burst: ack tracks out_ready.
    apply(mk(1,0,0,0, 0,0,0,0,2'd0), 0, "rnd_reset");
    apply(mk(0,1,0,0, 0,0,0,0,2'd0), 0, "rnd_idle");
    begin
      logic [1:0] cnt;
      cnt = 2'd0;
      for (int k = 0; k < 12; k++) begin
        logic rdy;
        rdy = 1'($urandom_range(0, 1));
        apply(mk(0,1,0,rdy, 0,1,rdy,0,cnt), 0, $sformatf("rnd[%0d]", k));
        if (rdy) cnt = cnt + 2'd1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
